// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-facing signal bundle for alu_issue_ctrl.
// slave = the issue controller; master = decode stage, alu_32 and result consumer.
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_funct;
    logic [31:0] in_a;
    logic [31:0] in_b;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        alu_err_invalid_control;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_trap;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_funct, in_a, in_b,
        output in_ready,
        output alu_a, alu_b, alu_control,
        input  alu_result, alu_zero, alu_overflow, alu_err_invalid_control,
        output out_valid, out_result, out_zero, out_trap, out_illegal,
        input  out_ready
    );

    modport master (
        output in_valid, in_funct, in_a, in_b,
        input  in_ready,
        input  alu_a, alu_b, alu_control,
        output alu_result, alu_zero, alu_overflow, alu_err_invalid_control,
        input  out_valid, out_result, out_zero, out_trap, out_illegal,
        output out_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one MIPS R-type op to alu_32, waits its fixed latency and holds the
// captured result/flags on a valid/ready port. Single outstanding op.
//
// state | meaning
// IDLE  | ready for a new op
// WAIT  | operands driven to alu_32, counting down its latency
// HOLD  | result presented, waiting for out_ready
module alu_issue_ctrl #(
    parameter int         ALU_LATENCY = 1,
    parameter logic [3:0] CTL_AND     = 4'b0000,
    parameter logic [3:0] CTL_OR      = 4'b0001,
    parameter logic [3:0] CTL_ADD     = 4'b0010,
    parameter logic [3:0] CTL_ADDU    = 4'b0011,
    parameter logic [3:0] CTL_SUB     = 4'b0110,
    parameter logic [3:0] CTL_SLT     = 4'b0111,
    parameter logic [3:0] CTL_NOR     = 4'b1100
) (
    input  logic            clock,
    input  logic            reset,
    alu_issue_ctrl_if.slave bus
);
    localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [3:0]         ctl_q, ctl_d;
    logic               trap_en_q, trap_en_d;
    logic [31:0]        res_q, res_d;
    logic               zero_q, zero_d;
    logic               trap_q, trap_d;
    logic               ill_q, ill_d;

    logic               dec_legal;
    logic [3:0]         dec_ctl;
    logic               dec_trap;

    always_comb begin
        dec_legal = 1'b1;
        dec_ctl   = CTL_AND;
        dec_trap  = 1'b0;
        case (bus.in_funct)
            6'h20: begin dec_ctl = CTL_ADD; dec_trap = 1'b1; end
            6'h21: dec_ctl = CTL_ADDU;
            6'h22: begin dec_ctl = CTL_SUB; dec_trap = 1'b1; end
            6'h23: dec_ctl = CTL_SUB;
            6'h24: dec_ctl = CTL_AND;
            6'h25: dec_ctl = CTL_OR;
            6'h27: dec_ctl = CTL_NOR;
            6'h2A: dec_ctl = CTL_SLT;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        ctl_d     = ctl_q;
        trap_en_d = trap_en_q;
        res_d     = res_q;
        zero_d    = zero_q;
        trap_d    = trap_q;
        ill_d     = ill_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (dec_legal) begin
                        a_d       = bus.in_a;
                        b_d       = bus.in_b;
                        ctl_d     = dec_ctl;
                        trap_en_d = dec_trap;
                        cnt_d     = CNT_W'(ALU_LATENCY);
                        state_d   = WAIT;
                    end else begin
                        // Illegal funct never reaches the ALU; report it directly.
                        res_d   = '0;
                        zero_d  = 1'b0;
                        trap_d  = 1'b0;
                        ill_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res_d   = bus.alu_result;
                    zero_d  = bus.alu_zero;
                    trap_d  = bus.alu_overflow & trap_en_q & ~bus.alu_err_invalid_control;
                    ill_d   = bus.alu_err_invalid_control;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ctl_q     <= CTL_AND;
            trap_en_q <= 1'b0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            trap_q    <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctl_q     <= ctl_d;
            trap_en_q <= trap_en_d;
            res_q     <= res_d;
            zero_q    <= zero_d;
            trap_q    <= trap_d;
            ill_q     <= ill_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == HOLD);
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_control = ctl_q;
    assign bus.out_result  = res_q;
    assign bus.out_zero    = zero_q;
    assign bus.out_trap    = trap_q;
    assign bus.out_illegal = ill_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered (1-edge) alu_32 model.
module tb_alu_issue_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(.ALU_LATENCY(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // alu_32 reference behaviour, one clock edge of latency.
    logic [31:0] m_r;
    logic        m_ov, m_inv;
    always @(posedge clock) begin
        m_r = 32'h0; m_ov = 1'b0; m_inv = 1'b0;
        case (bus.alu_control)
            4'b0000: m_r = bus.alu_a & bus.alu_b;
            4'b0001: m_r = bus.alu_a | bus.alu_b;
            4'b0010: begin
                m_r  = bus.alu_a + bus.alu_b;
                m_ov = (bus.alu_a[31] == bus.alu_b[31]) && (m_r[31] != bus.alu_a[31]);
            end
            4'b0011: m_r = bus.alu_a + bus.alu_b;
            4'b0110: begin
                m_r  = bus.alu_a - bus.alu_b;
                m_ov = (bus.alu_a[31] != bus.alu_b[31]) && (m_r[31] != bus.alu_a[31]);
            end
            4'b0111: m_r = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'h1 : 32'h0;
            4'b1100: m_r = ~(bus.alu_a | bus.alu_b);
            default: m_inv = 1'b1;
        endcase
        bus.alu_result              <= m_r;
        bus.alu_zero                <= (m_r == 32'h0);
        bus.alu_overflow            <= m_ov;
        bus.alu_err_invalid_control <= m_inv;
    end

    // Last legally issued operands, for checking that an illegal op leaves them alone.
    logic [31:0] last_a, last_b;
    logic [3:0]  last_ctl;

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy, output logic [31:0] res,
                          output logic z, output logic t, output logic il, output logic [3:0] ctl);
        bit seen = 0;
        lat = -1; busy = 0; res = 'x; z = 'x; t = 'x; il = 'x; ctl = 'x;
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_funct = f; bus.in_a = a; bus.in_b = b;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k == 0) begin
                bus.in_valid = 1'b0;
                ctl = bus.alu_control;
            end
            if (!seen && bus.out_valid) begin
                seen = 1; lat = k;
                res = bus.out_result; z = bus.out_zero; t = bus.out_trap; il = bus.out_illegal;
            end
            if (!bus.in_ready) busy++;
            else if (seen) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_tests++; if ({bus.out_result, bus.out_zero, bus.out_trap, bus.out_illegal} !== 35'h0) begin
            n_fail++; $display("FAIL reset_out_fields got %h/%b%b%b want 0", bus.out_result, bus.out_zero, bus.out_trap, bus.out_illegal); end
        n_tests++; if ({bus.alu_a, bus.alu_b, bus.alu_control} !== 68'h0) begin
            n_fail++; $display("FAIL reset_alu_regs got %h %h %h want 0 0 0", bus.alu_a, bus.alu_b, bus.alu_control); end
    endtask

    task automatic test_add();
        int lat, busy; logic [31:0] r; logic z, t, il; logic [3:0] c;
        run_op(6'h20, 32'd3, 32'd1, lat, busy, r, z, t, il, c);
        last_a = 32'd3; last_b = 32'd1; last_ctl = 4'b0010;
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got %0d want 2", lat); end
        n_tests++; if (busy !== 3) begin n_fail++; $display("FAIL add_in_ready_low got %0d want 3", busy); end
        n_tests++; if (r !== 32'd4) begin n_fail++; $display("FAIL add_result got %h want 4", r); end
        n_tests++; if ({z, t, il} !== 3'b000) begin n_fail++; $display("FAIL add_flags got %b want 000", {z, t, il}); end
        n_tests++; if (c !== 4'b0010) begin n_fail++; $display("FAIL add_ctl got %b want 0010", c); end
    endtask

    task automatic test_overflow();
        int lat, busy; logic [31:0] r; logic z, t, il; logic [3:0] c;
        run_op(6'h20, 32'h7FFFFFFF, 32'd1, lat, busy, r, z, t, il, c);
        n_tests++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL add_ovf_result got %h want 80000000", r); end
        n_tests++; if (t !== 1'b1 || il !== 1'b0) begin n_fail++; $display("FAIL add_ovf_trap got t=%b il=%b want t=1 il=0", t, il); end
        run_op(6'h21, 32'h7FFFFFFF, 32'd1, lat, busy, r, z, t, il, c);
        n_tests++; if (c !== 4'b0011) begin n_fail++; $display("FAIL addu_ctl got %b want 0011", c); end
        n_tests++; if (r !== 32'h80000000 || t !== 1'b0) begin n_fail++; $display("FAIL addu_result got %h t=%b want 80000000 t=0", r, t); end
    endtask

    task automatic test_sub();
        int lat, busy; logic [31:0] r; logic z, t, il; logic [3:0] c;
        run_op(6'h23, 32'h80000000, 32'd1, lat, busy, r, z, t, il, c);
        n_tests++; if (c !== 4'b0110) begin n_fail++; $display("FAIL subu_ctl got %b want 0110", c); end
        n_tests++; if (r !== 32'h7FFFFFFF || t !== 1'b0) begin n_fail++; $display("FAIL subu_result got %h t=%b want 7fffffff t=0", r, t); end
        run_op(6'h22, 32'h80000000, 32'd1, lat, busy, r, z, t, il, c);
        n_tests++; if (c !== 4'b0110 || t !== 1'b1) begin n_fail++; $display("FAIL sub_trap got ctl=%b t=%b want 0110 t=1", c, t); end
    endtask

    task automatic test_slt_zero();
        int lat, busy; logic [31:0] r; logic z, t, il; logic [3:0] c;
        run_op(6'h2A, 32'hFFFFFFFF, 32'd0, lat, busy, r, z, t, il, c);
        n_tests++; if (r !== 32'd1 || c !== 4'b0111) begin n_fail++; $display("FAIL slt_result got %h ctl=%b want 1 0111", r, c); end
        run_op(6'h22, 32'd5, 32'd5, lat, busy, r, z, t, il, c);
        n_tests++; if (r !== 32'd0 || z !== 1'b1 || t !== 1'b0) begin n_fail++; $display("FAIL sub_zero got %h z=%b t=%b want 0 z=1 t=0", r, z, t); end
    endtask

    task automatic test_logic();
        int lat, busy; logic [31:0] r; logic z, t, il; logic [3:0] c;
        run_op(6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, lat, busy, r, z, t, il, c);
        n_tests++; if (r !== 32'h00F0_1200 || c !== 4'b0000) begin n_fail++; $display("FAIL and_result got %h ctl=%b want 00f01200 0000", r, c); end
        run_op(6'h25, 32'hF000_000F, 32'h0000_FF00, lat, busy, r, z, t, il, c);
        n_tests++; if (r !== 32'hF000_FF0F || c !== 4'b0001) begin n_fail++; $display("FAIL or_result got %h ctl=%b want f000ff0f 0001", r, c); end
        run_op(6'h27, 32'hF000_000F, 32'h0000_FF00, lat, busy, r, z, t, il, c);
        last_a = 32'hF000_000F; last_b = 32'h0000_FF00; last_ctl = 4'b1100;
        n_tests++; if (r !== 32'h0FFF_00F0 || c !== 4'b1100) begin n_fail++; $display("FAIL nor_result got %h ctl=%b want 0fff00f0 1100", r, c); end
    endtask

    task automatic test_illegal_hold();
        int bad = 0;
        @(negedge clock);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_funct = 6'h3F; bus.in_a = 32'd123; bus.in_b = 32'd456;
        @(negedge clock);
        bus.in_valid = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_valid got v=%b il=%b want 1 1", bus.out_valid, bus.out_illegal); end
        n_tests++; if (bus.out_result !== 32'h0 || bus.out_trap !== 1'b0 || bus.out_zero !== 1'b0) begin
            n_fail++; $display("FAIL illegal_fields got %h z=%b t=%b want 0 0 0", bus.out_result, bus.out_zero, bus.out_trap); end
        n_tests++; if (bus.alu_a !== last_a || bus.alu_b !== last_b || bus.alu_control !== last_ctl) begin
            n_fail++; $display("FAIL illegal_alu_unchanged got %h %h %b want %h %h %b",
                              bus.alu_a, bus.alu_b, bus.alu_control, last_a, last_b, last_ctl); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_illegal !== 1'b1 || bus.out_result !== 32'h0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
        bus.out_ready = 1'b1;
        @(negedge clock);
        n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL drain got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
        n_tests++; if (bus.out_illegal !== 1'b1) begin n_fail++; $display("FAIL drain_keep got il=%b want 1", bus.out_illegal); end
    endtask

    task automatic test_reset_mid();
        int lat, busy, bad = 0; logic [31:0] r; logic z, t, il; logic [3:0] c;
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_funct = 6'h24; bus.in_a = 32'hF; bus.in_b = 32'h3;
        @(negedge clock);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state got rdy=%b v=%b want 1 0", bus.in_ready, bus.out_valid); end
        n_tests++; if ({bus.out_result, bus.out_zero, bus.out_trap, bus.out_illegal} !== 35'h0 ||
                       {bus.alu_a, bus.alu_b, bus.alu_control} !== 68'h0) begin
            n_fail++; $display("FAIL midreset_values got %h il=%b alu %h %h %b want zeros",
                              bus.out_result, bus.out_illegal, bus.alu_a, bus.alu_b, bus.alu_control); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (bus.out_valid !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL midreset_no_output got %0d valid cycles want 0", bad); end
        run_op(6'h25, 32'h0000_00A0, 32'h0000_000B, lat, busy, r, z, t, il, c);
        n_tests++; if (lat !== 2 || r !== 32'h0000_00AB || il !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_op got lat=%0d r=%h il=%b want 2 000000ab 0", lat, r, il); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_funct = 6'h0; bus.in_a = 32'h0; bus.in_b = 32'h0;
        bus.out_ready = 1'b1;
        last_a = '0; last_b = '0; last_ctl = '0;
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_slt_zero();
        test_logic();
        test_illegal_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator that sits between the decode stage and alu_32.
- Accepts one R-type operation: MIPS funct code plus two 32-bit operands, over a valid/ready handshake.
- Translates funct into the alu_32 4-bit control code and drives alu_32's operand/control inputs from registers.
- Waits the ALU's fixed latency, captures result and flags, and holds them on a valid/ready output port. Trap and illegal status are resolved per instruction.

Parameters:
ALU_LATENCY, 1, clock edges between alu_32 input change and registered result valid (0 = combinational ALU)
CTL_AND, 4'b0000, alu_32 AND control code
CTL_OR, 4'b0001, alu_32 OR control code
CTL_ADD, 4'b0010, alu_32 signed add control code
CTL_ADDU, 4'b0011, alu_32 unsigned add control code
CTL_SUB, 4'b0110, alu_32 subtract control code
CTL_SLT, 4'b0111, alu_32 set-less-than control code
CTL_NOR, 4'b1100, alu_32 NOR control code

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream operation valid
in_ready  out  1  block can accept an operation
in_funct  in  6  MIPS R-type funct field
in_a  in  32  operand a (rs)
in_b  in  32  operand b (rt)
alu_a  out  32  to alu_32 input_a
alu_b  out  32  to alu_32 input_b
alu_control  out  4  to alu_32 control
alu_result  in  32  from alu_32 result
alu_zero  in  1  from alu_32 zero
alu_overflow  in  1  from alu_32 err_overflow
alu_err_invalid_control  in  1  from alu_32 err_invalid_control
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_result  out  32  captured ALU result
out_zero  out  1  captured zero flag
out_trap  out  1  arithmetic overflow trap (signed add/sub only)
out_illegal  out  1  unsupported funct or ALU rejected control

Behaviour:
- Only synchronous reset is used. On the reset edge:
  - state=IDLE, in_ready=1, out_valid=0.
  - out_result=0, out_zero=0, out_trap=0, out_illegal=0.
  - alu_a=0, alu_b=0, alu_control=CTL_AND.
- Reset mid-operation discards the in-flight op with no output.
- Funct decode:
  - 0x20→ADD (trap enabled)
  - 0x21→ADDU
  - 0x22→SUB (trap enabled)
  - 0x23→SUB (trap disabled; subu)
  - 0x24→AND
  - 0x25→OR
  - 0x27→NOR
  - 0x2A→SLT
  - All others are illegal.
- FSM states: IDLE, WAIT, HOLD. Single outstanding op. in_ready = (state==IDLE), combinational from state only.
- IDLE:
  - If in_valid at an edge and funct is legal: load alu_a/alu_b/alu_control and the trap-enable bit, set cnt=ALU_LATENCY, go WAIT.
  - If in_valid at an edge and funct is illegal: ALU regs unchanged, out_result=0, out_zero=0, out_trap=0, out_illegal=1, out_valid=1, go HOLD (result visible 1 cycle after accept).
- WAIT:
  - cnt!=0: cnt decrements each edge.
  - cnt==0 at an edge: capture out_result=alu_result, out_zero=alu_zero, out_trap=alu_overflow & trap_en, out_illegal=alu_err_invalid_control; out_valid=1; go HOLD.
  - Accept-to-out_valid latency = ALU_LATENCY+1 edges.
- HOLD:
  - Outputs stable while out_valid=1 && out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go IDLE.
  - Output fields keep their last value after drain.
- alu_a/alu_b/alu_control stay constant from accept through HOLD.
- Throughput: next accept no earlier than the edge after drain.
- out_trap and out_illegal are mutually exclusive; when alu_err_invalid_control=1, out_trap is forced to 0.
- cnt width = $clog2(ALU_LATENCY+1), minimum 1.

Test Plan:
- Reset, then funct 0x20, a=3, b=1, ALU_LATENCY=1, out_ready=1 → in_ready low for 3 cycles; out_valid high exactly 2 edges after accept; out_result=4, out_zero=0, out_trap=0; alu_control=CTL_ADD.
- funct 0x20, a=0x7FFFFFFF, b=1 → out_result=0x80000000, out_trap=1. Same operands with funct 0x21 → alu_control=CTL_ADDU, out_trap=0.
- funct 0x23, a=0x80000000, b=1 → alu_control=CTL_SUB, out_result=0x7FFFFFFF, out_trap=0. With funct 0x22 → out_trap=1.
- funct 0x2A, a=0xFFFFFFFF, b=0 → out_result=1. Then funct 0x22, a=b=5 → out_result=0, out_zero=1.
- Illegal funct 0x3F → out_valid 1 edge after accept, out_illegal=1, out_result=0, alu_* unchanged. Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0. Raise out_ready → in_ready=1 on the next cycle.
- Assert reset during WAIT (e.g. 1 cycle after accept of 0x24) → next cycle state IDLE, out_valid=0, all outputs at reset values. A subsequent op completes normally.
